soda_vend_ctrl: RTL and testbench

Parametrised multi-product soda vending controller: per-slot price table, coin accumulation register, compare, dispense and change-return FSM.
Successor to the single-price soda datapath (tot register, a/s inputs, tot_lt_s compare), generalised to N_SODA slots and AMT_W-bit amounts.
Adds coin rejection and a valid/ready change-return handshake.
Sits between the coin acceptor / selection buttons and the dispense and change mechanisms.

---
 rtl/soda_vend_ctrl.sv | 139 +++++++++++++
 tb/tb_soda_vend_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soda_vend_ctrl.sv
// Multi-slot soda vending controller: price table, coin total, dispense and change handshake.
// Optional refund (cancel input) is compiled in with `define SODA_REFUND_EN.
module soda_vend_ctrl #(
    parameter int AMT_W  = 8,
    parameter int N_SODA = 4,
    parameter int SEL_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             price_wr,
    input  logic [SEL_W-1:0] price_sel,
    input  logic [AMT_W-1:0] price_din,
    input  logic             coin_valid,
    input  logic [AMT_W-1:0] coin_amt,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] sel,
    output logic [AMT_W-1:0] tot,
    output logic             tot_lt_s,
    output logic             coin_rej,
    output logic             disp,
    output logic [SEL_W-1:0] disp_sel,
    output logic             chg_valid,
    output logic [AMT_W-1:0] chg_amt,
    input  logic             chg_ready
`ifdef SODA_REFUND_EN
   ,input  logic             cancel
`endif
);

    localparam int SLOTS = 1 << SEL_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    state_t           state, state_n;
    logic [AMT_W-1:0] tot_n;
    logic [SEL_W-1:0] lat_sel, lat_sel_n;
    logic [AMT_W-1:0] lat_price, lat_price_n;
    logic             coin_rej_n;
    logic [AMT_W-1:0] price_tab [SLOTS];
    logic [SLOTS-1:0] slot_ok;
    logic [AMT_W:0]   coin_sum;
    logic             coin_ok;
    logic             cancel_req;

`ifdef SODA_REFUND_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < SLOTS; i++) slot_ok[i] = (i < N_SODA);
    end

    assign tot_lt_s  = tot < lat_price;
    assign disp      = (state == S_DISPENSE);
    assign disp_sel  = disp ? lat_sel : '0;
    assign chg_valid = (state == S_CHANGE);
    assign chg_amt   = tot;

    // Extra carry bit detects a coin that would push the total past the register range.
    assign coin_sum = {1'b0, tot} + {1'b0, coin_amt};
    assign coin_ok  = coin_valid && !cancel_req && !coin_sum[AMT_W] &&
                      ((state == S_IDLE) || ((state == S_COLLECT) && tot_lt_s));

    always_comb begin
        state_n     = state;
        tot_n       = tot;
        lat_sel_n   = lat_sel;
        lat_price_n = lat_price;
        coin_rej_n  = coin_valid && !coin_ok;
        if (coin_ok) tot_n = coin_sum[AMT_W-1:0];
        case (state)
            S_IDLE: begin
                if (cancel_req && (tot != '0)) begin
                    state_n = S_CHANGE;
                end else if (sel_valid && slot_ok[sel]) begin
                    lat_sel_n   = sel;
                    lat_price_n = price_tab[sel];
                    state_n     = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // A fresh selection re-latches and re-evaluates the total next cycle.
                if (cancel_req) begin
                    state_n = S_CHANGE;
                end else if (sel_valid && slot_ok[sel]) begin
                    lat_sel_n   = sel;
                    lat_price_n = price_tab[sel];
                end else if (!tot_lt_s) begin
                    state_n = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                tot_n = tot - lat_price;
                if (tot != lat_price) begin
                    state_n = S_CHANGE;
                end else begin
                    state_n     = S_IDLE;
                    lat_sel_n   = '0;
                    lat_price_n = '0;
                end
            end
            S_CHANGE: begin
                if (chg_ready) begin
                    tot_n       = '0;
                    state_n     = S_IDLE;
                    lat_sel_n   = '0;
                    lat_price_n = '0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            tot       <= '0;
            lat_sel   <= '0;
            lat_price <= '0;
            coin_rej  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) price_tab[i] <= '0;
        end else begin
            state     <= state_n;
            tot       <= tot_n;
            lat_sel   <= lat_sel_n;
            lat_price <= lat_price_n;
            coin_rej  <= coin_rej_n;
            if (price_wr && slot_ok[price_sel]) price_tab[price_sel] <= price_din;
        end
    end

endmodule

// File: tb/tb_soda_vend_ctrl.sv
// Bench for soda_vend_ctrl: directed scenarios plus random traffic checked against a
// transaction-level credit/selection model and a dispense scoreboard.
module tb_soda_vend_ctrl;

    localparam int AMT_W  = 8;
    localparam int N_SODA = 4;
    localparam int SEL_W  = 2;
    localparam int AMT_MAX = (1 << AMT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             price_wr = 1'b0;
    logic [SEL_W-1:0] price_sel = '0;
    logic [AMT_W-1:0] price_din = '0;
    logic             coin_valid = 1'b0;
    logic [AMT_W-1:0] coin_amt = '0;
    logic             sel_valid = 1'b0;
    logic [SEL_W-1:0] sel = '0;
    logic             chg_ready = 1'b0;
    logic             cancel = 1'b0;
    logic [AMT_W-1:0] tot;
    logic             tot_lt_s;
    logic             coin_rej;
    logic             disp;
    logic [SEL_W-1:0] disp_sel;
    logic             chg_valid;
    logic [AMT_W-1:0] chg_amt;

    soda_vend_ctrl #(.AMT_W(AMT_W), .N_SODA(N_SODA), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst),
        .price_wr(price_wr), .price_sel(price_sel), .price_din(price_din),
        .coin_valid(coin_valid), .coin_amt(coin_amt),
        .sel_valid(sel_valid), .sel(sel),
        .tot(tot), .tot_lt_s(tot_lt_s), .coin_rej(coin_rej),
        .disp(disp), .disp_sel(disp_sel),
        .chg_valid(chg_valid), .chg_amt(chg_amt), .chg_ready(chg_ready)
`ifdef SODA_REFUND_EN
       ,.cancel(cancel)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: credit held, selection held, pending dispense / change.
    int                m_prices[N_SODA];
    int                m_tot = 0;
    bit                m_held = 0;
    int                m_sel = 0;
    int                m_price = 0;
    bit                m_disp = 0;
    bit                m_chg = 0;
    bit                m_rej = 0;
    logic [SEL_W-1:0]  exp_q[$];

    task automatic model_next();
        int  n_tot, n_sel, n_price;
        bit  n_held, n_disp, n_chg, can, open, accept;
        if (rst) begin
            foreach (m_prices[i]) m_prices[i] = 0;
            m_tot = 0; m_held = 0; m_sel = 0; m_price = 0;
            m_disp = 0; m_chg = 0; m_rej = 0;
            exp_q.delete();
            return;
        end
`ifdef SODA_REFUND_EN
        can = cancel;
`else
        can = 0;
`endif
        n_tot = m_tot; n_sel = m_sel; n_price = m_price;
        n_held = m_held; n_disp = 0; n_chg = m_chg;
        open   = !m_disp && !m_chg && (!m_held || m_tot < m_price);
        accept = coin_valid && !can && open && (m_tot + int'(coin_amt) <= AMT_MAX);
        if (m_chg) begin
            if (chg_ready) begin
                n_tot = 0; n_chg = 0; n_held = 0; n_price = 0; n_sel = 0;
            end
        end else if (m_disp) begin
            n_tot = m_tot - m_price;
            if (n_tot > 0) n_chg = 1;
            else begin
                n_held = 0; n_price = 0; n_sel = 0;
            end
        end else if (can && (m_held || m_tot > 0)) begin
            n_chg = 1;
        end else if (sel_valid && int'(sel) < N_SODA) begin
            n_held = 1; n_sel = int'(sel); n_price = m_prices[int'(sel)];
        end else if (m_held && m_tot >= m_price) begin
            n_disp = 1;
            exp_q.push_back(SEL_W'(m_sel));
        end
        if (accept) n_tot = n_tot + int'(coin_amt);
        m_rej = coin_valid && !accept;
        if (price_wr && int'(price_sel) < N_SODA) m_prices[int'(price_sel)] = int'(price_din);
        m_tot = n_tot; m_sel = n_sel; m_price = n_price;
        m_held = n_held; m_disp = n_disp; m_chg = n_chg;
    endtask

    task automatic model_check();
        logic [SEL_W-1:0] e;
        check("tot", 32'(tot), 32'(m_tot));
        check("coin_rej", 32'(coin_rej), 32'(m_rej));
        check("disp", 32'(disp), 32'(m_disp));
        check("chg_valid", 32'(chg_valid), 32'(m_chg));
        if (m_chg) check("chg_amt", 32'(chg_amt), 32'(m_tot));
        if (m_disp && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("disp_sel", 32'(disp_sel), 32'(e));
        end
        if (m_held && !m_disp && !m_chg) check("tot_lt_s", 32'(tot_lt_s), 32'(m_tot < m_price));
    endtask

    // driver tasks: inputs are set at the falling edge, consumed at the next rising edge
    task automatic tick();
        model_next();
        @(posedge clk);
        @(negedge clk);
        model_check();
        coin_valid = 0; sel_valid = 0; price_wr = 0; cancel = 0; chg_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
        check("rst_tot", 32'(tot), 0);
        check("rst_lt", 32'(tot_lt_s), 0);
        check("rst_disp", 32'(disp), 0);
        check("rst_disp_sel", 32'(disp_sel), 0);
        check("rst_chg_valid", 32'(chg_valid), 0);
        check("rst_coin_rej", 32'(coin_rej), 0);
    endtask

    task automatic write_price(input int s, input int p);
        price_wr = 1; price_sel = SEL_W'(s); price_din = AMT_W'(p);
        tick();
    endtask

    task automatic select(input int s);
        sel_valid = 1; sel = SEL_W'(s);
        tick();
    endtask

    task automatic coin(input int a);
        coin_valid = 1; coin_amt = AMT_W'(a);
        tick();
    endtask

    int coin_tab[6] = '{5, 10, 25, 50, 100, 200};

    initial begin
        @(negedge clk);
        do_reset();

        // price 60, partial credit, then overpay by 5
        write_price(2, 60);
        select(2);
        coin(25); coin(10); coin(5);
        check("tp1_tot40", 32'(tot), 40);
        check("tp1_lt", 32'(tot_lt_s), 1);
        coin(25);
        check("tp1_tot65", 32'(tot), 65);
        check("tp1_nodisp_yet", 32'(disp), 0);
        tick();
        check("tp1_disp", 32'(disp), 1);
        check("tp1_disp_sel", 32'(disp_sel), 2);
        tick();
        check("tp1_chg_valid", 32'(chg_valid), 1);
        check("tp1_chg_amt", 32'(chg_amt), 5);
        chg_ready = 1;
        tick();
        check("tp1_tot_cleared", 32'(tot), 0);
        check("tp1_chg_done", 32'(chg_valid), 0);

        // exact payment, no change
        write_price(0, 50);
        select(0);
        coin(25); coin(25);
        tick();
        check("tp2_disp", 32'(disp), 1);
        tick();
        check("tp2_tot", 32'(tot), 0);
        check("tp2_no_chg", 32'(chg_valid), 0);

        // overflow rejection at the top of the range
        write_price(1, 255);
        select(1);
        coin(200); coin(100);
        check("tp3_rej", 32'(coin_rej), 1);
        check("tp3_tot", 32'(tot), 200);
        tick();
        check("tp3_no_disp", 32'(disp), 0);
        do_reset();

        // change held under back-pressure
        write_price(3, 30);
        select(3);
        coin(40);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("tp4_chg_hold", 32'(chg_valid), 1);
            check("tp4_chg_amt", 32'(chg_amt), 10);
            if (i == 2) coin_valid = 1;
            if (i == 2) coin_amt = 5;
            if (i == 3) check("tp4_rej", 32'(coin_rej), 1);
            if (i == 3) begin
                price_wr = 1; price_sel = 3; price_din = 45;
            end
            tick();
        end
        chg_ready = 1;
        tick();
        select(3);
        coin(40);
        check("tp4_new_price_lt", 32'(tot_lt_s), 1);
        coin(5);
        tick();
        check("tp4_disp45", 32'(disp), 1);
        tick();
        check("tp4_tot0", 32'(tot), 0);

        // reset drops credit and the price table
        write_price(2, 60);
        coin(25); coin(10);
        check("tp5_idle_credit", 32'(tot), 35);
        select(2);
        do_reset();
        select(2);
        check("tp5_collect_nodisp", 32'(disp), 0);
        tick();
        check("tp5_free_disp", 32'(disp), 1);
        check("tp5_free_sel", 32'(disp_sel), 2);
        tick();
        check("tp5_no_chg", 32'(chg_valid), 0);

`ifdef SODA_REFUND_EN
        write_price(2, 60);
        select(2);
        coin(25); coin(10);
        cancel = 1;
        tick();
        check("rf_chg_valid", 32'(chg_valid), 1);
        check("rf_chg_amt", 32'(chg_amt), 35);
        check("rf_no_disp", 32'(disp), 0);
        chg_ready = 1;
        tick();
        select(2);
        coin(25); coin(25); coin(10);
        check("rf_tot60", 32'(tot), 60);
        cancel = 1;
        tick();
        check("rf_full_chg", 32'(chg_amt), 60);
        check("rf_full_valid", 32'(chg_valid), 1);
        check("rf_full_no_disp", 32'(disp), 0);
        chg_ready = 1;
        tick();
`endif

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 599) == 0);
            coin_valid = ($urandom_range(0, 2) == 0);
            coin_amt   = AMT_W'(coin_tab[$urandom_range(0, 5)]);
            sel_valid  = ($urandom_range(0, 7) == 0);
            sel        = SEL_W'($urandom_range(0, N_SODA - 1));
            price_wr   = ($urandom_range(0, 7) == 0);
            price_sel  = SEL_W'($urandom_range(0, N_SODA - 1));
            price_din  = AMT_W'(5 * $urandom_range(0, 51));
            chg_ready  = ($urandom_range(0, 2) == 0);
`ifdef SODA_REFUND_EN
            cancel     = ($urandom_range(0, 29) == 0);
`endif
            tick();
        end
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            chg_ready = 1;
            tick();
        end
        check("exp_q_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
